// File: rtl/ro_pkg.sv
// ----------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the channel readout scheduler: one-hot FSM state
// encoding, header/trailer tags, burst counter width and helpers that build
// the framing words written around each channel burst.
// ----------------------------------------------------------------------------
package ro_pkg;

  localparam int CNT_W  = 12;
  localparam int CH_W   = 4;
  localparam int WORD_W = 16;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [3:0] TRL_TAG = 4'hE;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_HEADER  = 4'b0010,
    ST_READ    = 4'b0100,
    ST_TRAILER = 4'b1000
  } state_e;

  // Header word: tag, granted channel, low byte of the burst sequence number.
  function automatic logic [WORD_W-1:0] make_header(input logic [CH_W-1:0] ch,
                                                    input logic [7:0]      seq);
    return {HDR_TAG, ch, seq};
  endfunction

  // Trailer word: tag and number of data words actually sent in the burst.
  function automatic logic [WORD_W-1:0] make_trailer(input logic [CNT_W-1:0] cnt);
    return {TRL_TAG, cnt};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at the channel just
// after ptr_i and wraps, so the last served channel has lowest priority.
//   req_i  in  NCH  request vector
//   ptr_i  in  4    last served channel index
//   gnt_o  out NCH  one-hot grant (all zero when no request)
//   idx_o  out 4    index of the granted channel
//   vld_o  out 1    a grant was made
// ----------------------------------------------------------------------------
module rr_arbiter
  import ro_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            vld_o
);

  logic take_s;

  // Two-pass priority search: first the channels above the pointer, then the
  // remaining ones from index 0, which together form the wrapped rotation.
  always_comb begin
    idx_o  = {CH_W{1'b0}};
    vld_o  = 1'b0;
    take_s = 1'b0;
    gnt_o  = {NCH{1'b0}};
    for (int j = 0; j < NCH; j++) begin
      take_s = !vld_o && req_i[j] && (5'(j) > {1'b0, ptr_i});
      idx_o  = take_s ? 4'(j) : idx_o;
      vld_o  = vld_o | take_s;
    end
    for (int j = 0; j < NCH; j++) begin
      take_s = !vld_o && req_i[j];
      idx_o  = take_s ? 4'(j) : idx_o;
      vld_o  = vld_o | take_s;
    end
    for (int j = 0; j < NCH; j++) begin
      gnt_o[j] = vld_o && (idx_o == 4'(j));
    end
  end

endmodule

// File: rtl/chan_ro_sched.sv
// ----------------------------------------------------------------------------
// chan_ro_sched
// Reads bursts from NCH digitizer channel FIFOs (show-ahead) into a single
// output FIFO. Each burst is framed as header, up to MAX_BURST data words,
// trailer. Channels are granted round-robin among enabled, non-empty ones.
//   CLK, RST   clock and synchronous active-high reset
//   CH_MASK    in  NCH     channel enable for arbitration
//   CH_DAVAIL  in  NCH     channel FIFO non-empty
//   CH_DATA    in  NCH*DW  channel FIFO head words, channel i at [i*DW +: DW]
//   CH_RDEN    out NCH     one-hot pop strobe (combinational)
//   OUT_FULL   in  1       output FIFO almost full
//   OUT_WREN   out 1       registered output write strobe
//   OUT_DATA   out DW      registered output word
//   BUSY       out 1       not idle
//   CUR_CH     out 4       granted channel, 0 while idle
// ----------------------------------------------------------------------------
module chan_ro_sched
  import ro_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    CH_MASK,
  input  logic [NCH-1:0]    CH_DAVAIL,
  input  logic [NCH*DW-1:0] CH_DATA,
  output logic [NCH-1:0]    CH_RDEN,
  input  logic              OUT_FULL,
  output logic              OUT_WREN,
  output logic [DW-1:0]     OUT_DATA,
  output logic              BUSY,
  output logic [CH_W-1:0]   CUR_CH
);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [NCH-1:0]     cur_oh_q, cur_oh_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [7:0]         seq_q, seq_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic               wren_q, wren_d;
  logic [DW-1:0]      data_q, data_d;

  logic [NCH-1:0]     req_s;
  logic [NCH-1:0]     gnt_s;
  logic [CH_W-1:0]    gnt_idx_s;
  logic               gnt_vld_s;
  logic               davail_cur_s;
  logic [DW-1:0]      head_word_s;
  logic               pop_s;

  assign req_s = CH_MASK & CH_DAVAIL;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i (req_s),
    .ptr_i (last_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .vld_o (gnt_vld_s)
  );

  // The granted channel is held one-hot, so status and data selection are
  // AND-OR muxes rather than variable-width indexing.
  assign davail_cur_s = |(CH_DAVAIL & cur_oh_q);

  // Head word of the granted channel.
  always_comb begin
    head_word_s = {DW{1'b0}};
    for (int j = 0; j < NCH; j++) begin
      head_word_s = head_word_s | (CH_DATA[j*DW +: DW] & {DW{cur_oh_q[j]}});
    end
  end

  assign pop_s   = (state_q == ST_READ) && davail_cur_s && !OUT_FULL &&
                   (wcnt_q < 12'(MAX_BURST));
  assign CH_RDEN = pop_s ? cur_oh_q : {NCH{1'b0}};

  // Next-state, burst bookkeeping and output-word selection.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cur_oh_d = cur_oh_q;
    wcnt_d   = wcnt_q;
    seq_d    = seq_q;
    last_d   = last_q;
    wren_d   = 1'b0;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_s) begin
          cur_ch_d = gnt_idx_s;
          cur_oh_d = gnt_s;
          wcnt_d   = {CNT_W{1'b0}};
          state_d  = ST_HEADER;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (!OUT_FULL) begin
          wren_d  = 1'b1;
          data_d  = make_header(cur_ch_q, seq_q);
          state_d = ST_READ;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_READ: begin
        // Almost-full stalls both popping and leaving the burst.
        if (OUT_FULL) begin
          state_d = ST_READ;
        end else if (pop_s) begin
          wren_d  = 1'b1;
          data_d  = head_word_s;
          wcnt_d  = wcnt_q + 12'd1;
        end else begin
          state_d = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (!OUT_FULL) begin
          wren_d   = 1'b1;
          data_d   = make_trailer(wcnt_q);
          seq_d    = seq_q + 8'd1;
          last_d   = cur_ch_q;
          cur_ch_d = {CH_W{1'b0}};
          cur_oh_d = {NCH{1'b0}};
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_TRAILER;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cur_ch_d = {CH_W{1'b0}};
        cur_oh_d = {NCH{1'b0}};
      end
    endcase
  end

  // State and output registers; reset leaves channel 0 first in line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cur_ch_q <= {CH_W{1'b0}};
      cur_oh_q <= {NCH{1'b0}};
      wcnt_q   <= {CNT_W{1'b0}};
      seq_q    <= 8'd0;
      last_q   <= 4'(NCH - 1);
      wren_q   <= 1'b0;
      data_q   <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      cur_oh_q <= cur_oh_d;
      wcnt_q   <= wcnt_d;
      seq_q    <= seq_d;
      last_q   <= last_d;
      wren_q   <= wren_d;
      data_q   <= data_d;
    end
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign CUR_CH   = cur_ch_q;
  assign OUT_WREN = wren_q;
  assign OUT_DATA = data_q;

endmodule

// File: tb/tb_chan_ro_sched.sv
// ----------------------------------------------------------------------------
// tb_chan_ro_sched
// Self-checking bench: channel FIFOs are modelled with queues, expected
// output words are pushed to a scoreboard when data is loaded and compared
// against each OUT_WREN word.
// ----------------------------------------------------------------------------
module tb_chan_ro_sched;

  localparam int NCH  = 4;
  localparam int MAXB = 256;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NCH-1:0]    CH_MASK;
  logic [NCH-1:0]    CH_DAVAIL;
  logic [NCH*16-1:0] CH_DATA;
  logic [NCH-1:0]    CH_RDEN;
  logic              OUT_FULL;
  logic              OUT_WREN;
  logic [15:0]       OUT_DATA;
  logic              BUSY;
  logic [3:0]        CUR_CH;

  logic [15:0] fifo_q [NCH][$];
  logic [15:0] sb_q [$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          wr_cnt  = 0;
  logic [3:0]  m_last;
  logic [7:0]  m_seq;

  chan_ro_sched #(.NCH(NCH), .DW(16), .MAX_BURST(MAXB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CH_MASK   (CH_MASK),
    .CH_DAVAIL (CH_DAVAIL),
    .CH_DATA   (CH_DATA),
    .CH_RDEN   (CH_RDEN),
    .OUT_FULL  (OUT_FULL),
    .OUT_WREN  (OUT_WREN),
    .OUT_DATA  (OUT_DATA),
    .BUSY      (BUSY),
    .CUR_CH    (CUR_CH)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Drive show-ahead FIFO status and head words from the queues.
  task automatic refresh();
    for (int c = 0; c < NCH; c++) begin
      CH_DAVAIL[c]         = (fifo_q[c].size() > 0);
      CH_DATA[c*16 +: 16]  = (fifo_q[c].size() > 0) ? fifo_q[c][0] : 16'h0000;
    end
  endtask

  // Predict the complete drain of the currently loaded FIFOs.
  task automatic predict();
    int used [NCH];
    int ch;
    int n;
    int c;
    logic found;
    for (int k = 0; k < NCH; k++) used[k] = 0;
    while (1) begin
      found = 1'b0;
      ch    = 0;
      for (int k = 1; k <= NCH; k++) begin
        c = (int'(m_last) + k) % NCH;
        if (!found && CH_MASK[c] && (fifo_q[c].size() > used[c])) begin
          found = 1'b1;
          ch    = c;
        end
      end
      if (!found) break;
      n = fifo_q[ch].size() - used[ch];
      if (n > MAXB) n = MAXB;
      sb_q.push_back({4'hA, 4'(ch), m_seq});
      for (int i = 0; i < n; i++) sb_q.push_back(fifo_q[ch][used[ch] + i]);
      used[ch] += n;
      sb_q.push_back({4'hE, 12'(n)});
      m_seq  = m_seq + 8'd1;
      m_last = 4'(ch);
    end
  endtask

  task automatic flush_all();
    for (int c = 0; c < NCH; c++) fifo_q[c].delete();
    sb_q.delete();
    m_last = 4'(NCH - 1);
    m_seq  = 8'd0;
    refresh();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    flush_all();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while ((k < budget) && !((sb_q.size() == 0) && !BUSY)) begin
      @(negedge CLK);
      k++;
    end
    check_eq(tag, 32'((sb_q.size() == 0) && !BUSY), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int t;
    int k;
    t = wr_cnt;
    k = 0;
    while ((k < budget) && (wr_cnt < t + n)) begin
      @(negedge CLK);
      k++;
    end
    check_eq("wr_progress", 32'(wr_cnt >= t + n), 32'd1);
  endtask

  // FIFO pops seen by the DUT at the clock edge.
  always @(posedge CLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (CH_RDEN[c] && (fifo_q[c].size() > 0)) fifo_q[c].delete(0);
    end
  end

  // Input refresh, strobe invariants and scoreboard comparison.
  always @(negedge CLK) begin
    refresh();
    check_eq("rden_onehot", 32'($countones(CH_RDEN) <= 1), 32'd1);
    if (!BUSY) check_eq("rden_idle", 32'(CH_RDEN), 32'd0);
    if (OUT_WREN) begin
      wr_cnt++;
      if (sb_q.size() == 0) check_eq("extra_wr", 32'(sb_q.size()), 32'd1);
      else check_eq("out_word", 32'(OUT_DATA), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    CH_MASK   = {NCH{1'b1}};
    OUT_FULL  = 1'b0;
    CH_DAVAIL = {NCH{1'b0}};
    CH_DATA   = {(NCH*16){1'b0}};
    m_last    = 4'(NCH - 1);
    m_seq     = 8'd0;
    repeat (3) @(negedge CLK);
    check_eq("rst_busy",  32'(BUSY),     32'd0);
    check_eq("rst_curch", 32'(CUR_CH),   32'd0);
    check_eq("rst_wren",  32'(OUT_WREN), 32'd0);
    check_eq("rst_data",  32'(OUT_DATA), 32'd0);
    check_eq("rst_rden",  32'(CH_RDEN),  32'd0);
    RST = 1'b0;

    // Channel 2 only, three words, fixed expected frame.
    @(negedge CLK);
    fifo_q[2].push_back(16'h0011);
    fifo_q[2].push_back(16'h0022);
    fifo_q[2].push_back(16'h0033);
    sb_q.push_back(16'hA200); sb_q.push_back(16'h0011); sb_q.push_back(16'h0022);
    sb_q.push_back(16'h0033); sb_q.push_back(16'hE003);
    refresh();
    wait_idle(60, "t_ch2_done");
    // Second burst must carry sequence 1.
    @(negedge CLK);
    fifo_q[2].push_back(16'h0044);
    sb_q.push_back(16'hA201); sb_q.push_back(16'h0044); sb_q.push_back(16'hE001);
    m_seq  = 8'd2;
    m_last = 4'd2;
    refresh();
    wait_idle(60, "t_seq1_done");

    // All channels after reset: order 0,1,2,3 then 0 again.
    do_reset();
    @(negedge CLK);
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 2; i++) fifo_q[c].push_back(16'h0B00 + 16'(c*16 + i));
    predict();
    refresh();
    wait_idle(200, "t_rr_round1");
    @(negedge CLK);
    for (int c = 0; c < NCH; c++) fifo_q[c].push_back(16'h0C00 + 16'(c));
    predict();
    refresh();
    wait_idle(200, "t_rr_round2");

    // 300 words on channel 1: split into 256 + 44.
    @(negedge CLK);
    for (int i = 0; i < 300; i++) fifo_q[1].push_back(16'h5A00 ^ 16'(i));
    predict();
    refresh();
    wait_idle(1500, "t_maxburst");

    // Output almost-full held five cycles in the middle of a burst.
    @(negedge CLK);
    for (int i = 0; i < 12; i++) fifo_q[0].push_back(16'h3300 + 16'(i));
    predict();
    refresh();
    wait_writes(4, 50);
    OUT_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_eq("full_wren", 32'(OUT_WREN), 32'd0);
      check_eq("full_rden", 32'(CH_RDEN),  32'd0);
      check_eq("full_busy", 32'(BUSY),     32'd1);
    end
    OUT_FULL = 1'b0;
    wait_idle(100, "t_full_done");

    // Data disappears between grant and READ: zero-length burst.
    @(negedge CLK);
    fifo_q[0].push_back(16'h7777);
    refresh();
    @(negedge CLK);
    check_eq("drop_busy", 32'(BUSY), 32'd1);
    fifo_q[0].delete();
    refresh();
    sb_q.push_back({4'hA, 4'd0, m_seq});
    sb_q.push_back(16'hE000);
    m_seq  = m_seq + 8'd1;
    m_last = 4'd0;
    wait_idle(60, "t_zero_len");

    // Reset in the middle of a channel-3 burst.
    do_reset();
    @(negedge CLK);
    for (int i = 0; i < 20; i++) fifo_q[3].push_back(16'h9000 + 16'(i));
    predict();
    refresh();
    wait_writes(5, 60);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("mid_rst_wren",  32'(OUT_WREN), 32'd0);
    check_eq("mid_rst_busy",  32'(BUSY),     32'd0);
    check_eq("mid_rst_curch", 32'(CUR_CH),   32'd0);
    flush_all();
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      fifo_q[0].push_back(16'h1100 + 16'(i));
      fifo_q[3].push_back(16'h1300 + 16'(i));
    end
    predict();
    refresh();
    wait_idle(100, "t_after_rst");

    // Channel 1 masked; 257 single-word bursts on channel 2 wrap SEQ.
    do_reset();
    CH_MASK = 4'b1101;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) fifo_q[1].push_back(16'h2100 + 16'(i));
    refresh();
    for (int it = 0; it < 257; it++) begin
      @(negedge CLK);
      fifo_q[2].push_back(16'(it) ^ 16'h6000);
      predict();
      refresh();
      wait_idle(40, "t_wrap_burst");
    end
    check_eq("masked_kept", 32'(fifo_q[1].size()), 32'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
